// File: rtl/sasanqua_axi_lite_master.sv
// sasanqua_axi_lite_master
//
// Single-outstanding AXI4-Lite master. A command (read or write) is accepted
// on CMD_VALID/CMD_READY, driven onto the AXI4-Lite channels, and the slave's
// answer is presented on RSP_* until RSP_READY consumes it.
//
// Ports
//   CLK, RST            : single clock, synchronous active-high reset
//   CMD_*               : command in  (VALID/READY, WRITE, ADDR, WDATA, WSTRB)
//   RSP_*               : response out (VALID/READY, RDATA, RESP, WRITE)
//   M_AXI_AW*/W*/B*     : AXI4-Lite write address / data / response channels
//   M_AXI_AR*/R*        : AXI4-Lite read address / data channels
//   BUSY                : high whenever the master is not idle
//   TIMEOUT             : sticky watchdog flag (only with the macro below)
//
// Configuration macro
//   SASANQUA_AXI_MASTER_TIMEOUT_EN : adds the TIMEOUT output and a wait counter
//   that flags a slave stalling for TIMEOUT_CYCLES cycles in one AXI state.
//   Without it the port and counter are absent.

module sasanqua_axi_lite_master #(
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ADDR_WIDTH = 16,
    parameter int TIMEOUT_CYCLES     = 1024
) (
    input  logic                            CLK,
    input  logic                            RST,
    // command
    input  logic                            CMD_VALID,
    output logic                            CMD_READY,
    input  logic                            CMD_WRITE,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   CMD_ADDR,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   CMD_WDATA,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0] CMD_WSTRB,
    // response
    output logic                            RSP_VALID,
    input  logic                            RSP_READY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   RSP_RDATA,
    output logic [1:0]                      RSP_RESP,
    output logic                            RSP_WRITE,
    // AXI write address
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]                      M_AXI_AWPROT,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    // AXI write data
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    // AXI write response
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    // AXI read address
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]                      M_AXI_ARPROT,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    // AXI read data
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY,
`ifdef SASANQUA_AXI_MASTER_TIMEOUT_EN
    output logic                            TIMEOUT,
`endif
    output logic                            BUSY
);

    // Elaboration-time parameter sanity checks.
    if (C_M_AXI_DATA_WIDTH != 32) begin : g_bad_data_width
        $error("sasanqua_axi_lite_master: only 32-bit data is supported");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("sasanqua_axi_lite_master: TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_WRESP = 3'd2,
        ST_READ  = 3'd3,
        ST_RDATA = 3'd4,
        ST_RESP  = 3'd5
    } state_t;

    state_t state_reg, state_next;

    logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_reg;
    logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_reg;
    logic [C_M_AXI_DATA_WIDTH/8-1:0] wstrb_reg;
    logic                            write_reg;
    logic [C_M_AXI_DATA_WIDTH-1:0]   rdata_reg;
    logic [1:0]                      resp_reg;
    // AW and W complete independently; each flag remembers its own handshake.
    logic                            aw_done_reg;
    logic                            w_done_reg;

    logic cmd_fire;
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic aw_complete, w_complete;

    assign cmd_fire    = CMD_VALID && CMD_READY;
    assign aw_hs       = M_AXI_AWVALID && M_AXI_AWREADY;
    assign w_hs        = M_AXI_WVALID && M_AXI_WREADY;
    assign b_hs        = M_AXI_BVALID && M_AXI_BREADY;
    assign ar_hs       = M_AXI_ARVALID && M_AXI_ARREADY;
    assign r_hs        = M_AXI_RVALID && M_AXI_RREADY;
    assign aw_complete = aw_done_reg || aw_hs;
    assign w_complete  = w_done_reg || w_hs;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (cmd_fire) state_next = CMD_WRITE ? ST_WRITE : ST_READ;
            ST_WRITE: if (aw_complete && w_complete) state_next = ST_WRESP;
            ST_WRESP: if (b_hs) state_next = ST_RESP;
            ST_READ:  if (ar_hs) state_next = ST_RDATA;
            ST_RDATA: if (r_hs) state_next = ST_RESP;
            ST_RESP:  if (RSP_READY) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. Every handshake output is gated by RST so nothing is
    // offered or accepted during the reset cycle itself, before the state
    // register has been forced back to IDLE.
    // ------------------------------------------------------------------
    always_comb begin
        CMD_READY     = 1'b0;
        BUSY          = 1'b0;
        M_AXI_AWVALID = 1'b0;
        M_AXI_WVALID  = 1'b0;
        M_AXI_BREADY  = 1'b0;
        M_AXI_ARVALID = 1'b0;
        M_AXI_RREADY  = 1'b0;
        RSP_VALID     = 1'b0;
        if (!RST) begin
            CMD_READY     = (state_reg == ST_IDLE);
            BUSY          = (state_reg != ST_IDLE);
            M_AXI_AWVALID = (state_reg == ST_WRITE) && !aw_done_reg;
            M_AXI_WVALID  = (state_reg == ST_WRITE) && !w_done_reg;
            M_AXI_BREADY  = (state_reg == ST_WRESP);
            M_AXI_ARVALID = (state_reg == ST_READ);
            M_AXI_RREADY  = (state_reg == ST_RDATA);
            RSP_VALID     = (state_reg == ST_RESP);
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            addr_reg    <= '0;
            wdata_reg   <= '0;
            wstrb_reg   <= '0;
            write_reg   <= 1'b0;
            rdata_reg   <= '0;
            resp_reg    <= 2'b00;
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
        end else begin
            if (cmd_fire) begin
                addr_reg    <= CMD_ADDR;
                wdata_reg   <= CMD_WDATA;
                wstrb_reg   <= CMD_WSTRB;
                write_reg   <= CMD_WRITE;
                aw_done_reg <= 1'b0;
                w_done_reg  <= 1'b0;
            end
            if (aw_hs) begin
                aw_done_reg <= 1'b1;
            end
            if (w_hs) begin
                w_done_reg <= 1'b1;
            end
            if (b_hs) begin
                resp_reg  <= M_AXI_BRESP;
                rdata_reg <= '0;
            end
            if (r_hs) begin
                resp_reg  <= M_AXI_RRESP;
                rdata_reg <= M_AXI_RDATA;
            end
        end
    end

    assign M_AXI_AWADDR = addr_reg;
    assign M_AXI_ARADDR = addr_reg;
    assign M_AXI_AWPROT = 3'b000;
    assign M_AXI_ARPROT = 3'b000;
    assign M_AXI_WDATA  = wdata_reg;
    assign M_AXI_WSTRB  = wstrb_reg;
    assign RSP_RDATA    = rdata_reg;
    assign RSP_RESP     = resp_reg;
    assign RSP_WRITE    = write_reg;

`ifdef SASANQUA_AXI_MASTER_TIMEOUT_EN
    // ------------------------------------------------------------------
    // Watchdog: counts cycles spent in one AXI wait state; the count restarts
    // on every state change and saturates at the limit. The flag is only
    // informative -- the FSM keeps waiting so the AXI protocol is never broken.
    // ------------------------------------------------------------------
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(TIMEOUT_CYCLES);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic              timeout_reg, timeout_next;
    logic              waiting;

    always_comb begin
        waiting       = (state_reg == ST_WRITE) || (state_reg == ST_WRESP) ||
                        (state_reg == ST_READ)  || (state_reg == ST_RDATA);
        wait_cnt_next = wait_cnt_reg;
        timeout_next  = timeout_reg;
        if (state_next != state_reg) begin
            wait_cnt_next = '0;
        end else if (waiting && (wait_cnt_reg != WAIT_MAX)) begin
            wait_cnt_next = wait_cnt_reg + 1'b1;
        end
        // The flag rises on the edge where the count reaches the limit.
        if (cmd_fire) begin
            timeout_next = 1'b0;
        end else if (waiting && (state_next == state_reg) && (wait_cnt_reg == WAIT_LAST)) begin
            timeout_next = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wait_cnt_reg <= '0;
            timeout_reg  <= 1'b0;
        end else begin
            wait_cnt_reg <= wait_cnt_next;
            timeout_reg  <= timeout_next;
        end
    end

    assign TIMEOUT = timeout_reg;
`endif

endmodule

// File: tb/tb_sasanqua_axi_lite_master.sv
`timescale 1ns/1ps
module tb_sasanqua_axi_lite_master;

    localparam int AW = 16;
`ifdef SASANQUA_AXI_MASTER_TIMEOUT_EN
    localparam int TO_CYCLES = 16;
`else
    localparam int TO_CYCLES = 1024;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [31:0]   cmd_wdata;
    logic [3:0]    cmd_wstrb;
    logic          rsp_valid, rsp_ready, rsp_write;
    logic [31:0]   rsp_rdata;
    logic [1:0]    rsp_resp;
    logic [AW-1:0] awaddr, araddr;
    logic [2:0]    awprot, arprot;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rvalid, rready;
    logic [31:0]   wdata, rdata;
    logic [3:0]    wstrb;
    logic [1:0]    bresp, rresp;
    logic          busy;
`ifdef SASANQUA_AXI_MASTER_TIMEOUT_EN
    logic          timeout;
`endif

    sasanqua_axi_lite_master #(
        .C_M_AXI_DATA_WIDTH(32),
        .C_M_AXI_ADDR_WIDTH(AW),
        .TIMEOUT_CYCLES(TO_CYCLES)
    ) dut (
        .CLK(clk), .RST(rst),
        .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready), .CMD_WRITE(cmd_write),
        .CMD_ADDR(cmd_addr), .CMD_WDATA(cmd_wdata), .CMD_WSTRB(cmd_wstrb),
        .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .RSP_RDATA(rsp_rdata),
        .RSP_RESP(rsp_resp), .RSP_WRITE(rsp_write),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready),
`ifdef SASANQUA_AXI_MASTER_TIMEOUT_EN
        .TIMEOUT(timeout),
`endif
        .BUSY(busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h expected 0x%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          aw_wait, w_wait, b_wait, ar_wait, r_wait;
        logic [1:0]  resp;
        logic [31:0] rdata;
        int          hold;
    } vec_t;

    typedef struct {
        bit          wr;
        logic [31:0] rdata;
        logic [1:0]  resp;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[8];

    function automatic vec_t mk(bit wr, logic [15:0] a, logic [31:0] d, logic [3:0] s,
                                int aww, int ww, int bw, int arw, int rw,
                                logic [1:0] resp, logic [31:0] rd, int hold);
        vec_t v;
        v.wr = wr; v.addr = a; v.wdata = d; v.wstrb = s;
        v.aw_wait = aww; v.w_wait = ww; v.b_wait = bw; v.ar_wait = arw; v.r_wait = rw;
        v.resp = resp; v.rdata = rd; v.hold = hold;
        return v;
    endfunction

    // Cycles from the acceptance cycle to the first RSP_VALID cycle, derived
    // from how long the slave keeps each channel waiting.
    function automatic int exp_latency(vec_t v);
        if (v.wr) return ((v.aw_wait > v.w_wait) ? v.aw_wait : v.w_wait) + 1 + v.b_wait + 1 + 1;
        return v.ar_wait + 1 + v.r_wait + 1 + 1;
    endfunction

    // ------------------------------------------------------------------
    // Slave model, stepped on the falling edge. A READY raised here while
    // VALID is high completes on the next rising edge and is retired on the
    // following falling edge.
    // ------------------------------------------------------------------
    int          cfg_aw_wait, cfg_w_wait, cfg_b_wait, cfg_ar_wait, cfg_r_wait;
    logic [1:0]  cfg_resp;
    logic [31:0] cfg_rdata;
    bit          slave_rst = 0;
    bit          tx_aw, tx_w, tx_ar, b_sent, r_sent;
    int          aw_hs_n, w_hs_n, b_hs_n, ar_hs_n, r_hs_n;
    int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    bit          aw_fire, w_fire, ar_fire, b_fire, r_fire;
    bit          aw_pend, w_pend, ar_pend;
    logic [31:0] seen_awaddr, seen_wdata, seen_araddr, pend_addr, pend_wdata;
    logic [3:0]  seen_wstrb;

    initial begin
        awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
        bresp = 0; rresp = 0; rdata = 0;
        aw_fire = 0; w_fire = 0; ar_fire = 0; b_fire = 0; r_fire = 0;
        aw_pend = 0; w_pend = 0; ar_pend = 0;
        forever begin
            @(negedge clk);
            if (slave_rst) begin
                awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
                aw_fire = 0; w_fire = 0; ar_fire = 0; b_fire = 0; r_fire = 0;
                aw_pend = 0; w_pend = 0; ar_pend = 0;
                aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
            end else begin
                if (aw_fire) begin
                    awready = 0; aw_fire = 0; aw_hs_n++; tx_aw = 1;
                    chk("awvalid_drop", awvalid, 0);
                end else if (aw_pend) begin
                    chk("awvalid_hold", awvalid, 1);
                    chk("awaddr_stable", awaddr, pend_addr);
                end
                if (w_fire) begin
                    wready = 0; w_fire = 0; w_hs_n++; tx_w = 1;
                    chk("wvalid_drop", wvalid, 0);
                end else if (w_pend) begin
                    chk("wvalid_hold", wvalid, 1);
                    chk("wdata_stable", wdata, pend_wdata);
                end
                if (ar_fire) begin
                    arready = 0; ar_fire = 0; ar_hs_n++; tx_ar = 1;
                    chk("arvalid_drop", arvalid, 0);
                end else if (ar_pend) begin
                    chk("arvalid_hold", arvalid, 1);
                end
                if (b_fire) begin bvalid = 0; b_fire = 0; b_hs_n++; end
                if (r_fire) begin rvalid = 0; r_fire = 0; r_hs_n++; end

                aw_pend = 0; w_pend = 0; ar_pend = 0;
                if (awvalid && !awready) begin
                    if (aw_cnt >= cfg_aw_wait) begin
                        awready = 1; aw_fire = 1; aw_cnt = 0; seen_awaddr = awaddr;
                    end else begin
                        aw_cnt++; aw_pend = 1; pend_addr = awaddr;
                    end
                end
                if (wvalid && !wready) begin
                    if (w_cnt >= cfg_w_wait) begin
                        wready = 1; w_fire = 1; w_cnt = 0; seen_wdata = wdata; seen_wstrb = wstrb;
                    end else begin
                        w_cnt++; w_pend = 1; pend_wdata = wdata;
                    end
                end
                if (arvalid && !arready) begin
                    if (ar_cnt >= cfg_ar_wait) begin
                        arready = 1; ar_fire = 1; ar_cnt = 0; seen_araddr = araddr;
                    end else begin
                        ar_cnt++; ar_pend = 1;
                    end
                end
                if (tx_aw && tx_w && !b_sent) begin
                    if (b_cnt >= cfg_b_wait) begin
                        bvalid = 1; bresp = cfg_resp; b_sent = 1; b_cnt = 0;
                    end else b_cnt++;
                end
                if (bvalid && bready) b_fire = 1;
                if (tx_ar && !r_sent) begin
                    if (r_cnt >= cfg_r_wait) begin
                        rvalid = 1; rdata = cfg_rdata; rresp = cfg_resp; r_sent = 1; r_cnt = 0;
                    end else r_cnt++;
                end
                if (rvalid && rready) r_fire = 1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver: offer a command (from a falling edge), push the expected
    // response, return the cycle number of acceptance (-1 if never accepted).
    // ------------------------------------------------------------------
    task automatic issue(input vec_t v, output int acc);
        exp_t e;
        int   n;
        cfg_aw_wait = v.aw_wait; cfg_w_wait = v.w_wait; cfg_b_wait = v.b_wait;
        cfg_ar_wait = v.ar_wait; cfg_r_wait = v.r_wait;
        cfg_resp = v.resp; cfg_rdata = v.rdata;
        tx_aw = 0; tx_w = 0; tx_ar = 0; b_sent = 0; r_sent = 0;
        aw_hs_n = 0; w_hs_n = 0; b_hs_n = 0; ar_hs_n = 0; r_hs_n = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
        e.wr = v.wr; e.rdata = v.wr ? 32'h0 : v.rdata; e.resp = v.resp;
        sb.push_back(e);
        cmd_valid = 1; cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata; cmd_wstrb = v.wstrb;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        if (!cmd_ready) begin
            chk("cmd_accept_bound", 0, 1);
            cmd_valid = 0;
            acc = -1;
            return;
        end
        acc = cyc;
        @(negedge clk);
        cmd_valid = 0;
        chk("busy_after_accept", busy, 1);
`ifdef SASANQUA_AXI_MASTER_TIMEOUT_EN
        chk("timeout_clear_on_accept", timeout, 0);
`endif
    endtask

    // Wait for the response, check latency / hold / payload, consume it.
    task automatic complete(input vec_t v, input int acc, input int idx);
        exp_t e;
        int   n;
        int   lat;
        n = 0;
        while (!rsp_valid && n < 200) begin @(negedge clk); n++; end
        if (!rsp_valid) begin
            chk("rsp_valid_bound", 0, 1);
            return;
        end
        lat = cyc - acc;
        chk("latency", lat, exp_latency(v));
        for (int h = 0; h < v.hold; h++) begin
            chk("hold_rsp_valid", rsp_valid, 1);
            chk("hold_rsp_resp", rsp_resp, v.resp);
            chk("hold_cmd_ready", cmd_ready, 0);
            @(negedge clk);
        end
        rsp_ready = 1;
        e = sb.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_resp", rsp_resp, e.resp);
        chk("rsp_write", rsp_write, e.wr);
        @(negedge clk);
        rsp_ready = 0;
        chk("rsp_valid_after", rsp_valid, 0);
        chk("cmd_ready_after", cmd_ready, 1);
        chk("busy_after", busy, 0);
        if (v.wr) begin
            chk("aw_hs_count", aw_hs_n, 1);
            chk("w_hs_count", w_hs_n, 1);
            chk("b_hs_count", b_hs_n, 1);
            chk("ar_hs_none", ar_hs_n, 0);
            chk("awaddr", seen_awaddr, {16'h0, v.addr});
            chk("wdata", seen_wdata, v.wdata);
            chk("wstrb", seen_wstrb, v.wstrb);
        end else begin
            chk("ar_hs_count", ar_hs_n, 1);
            chk("r_hs_count", r_hs_n, 1);
            chk("aw_hs_none", aw_hs_n, 0);
            chk("araddr", seen_araddr, {16'h0, v.addr});
        end
        $display("txn %0d %s addr=0x%h wdata=0x%h rdata=0x%h resp=%0d latency=%0d hold=%0d",
                 idx, v.wr ? "WR" : "RD", v.addr, v.wdata, rsp_rdata, v.resp, lat, v.hold);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        exp_t dummy;
        int   acc;
        int   n;

        vecs[0] = mk(1, 16'h0004, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 2'b00, 32'h0, 0);
        vecs[1] = mk(0, 16'h0008, 32'h0,       4'h0, 0, 0, 0, 0, 5, 2'b00, 32'h12345678, 0);
        vecs[2] = mk(1, 16'h0010, 32'hA5A55A5A, 4'h3, 4, 0, 0, 0, 0, 2'b00, 32'h0, 0);
        vecs[3] = mk(0, 16'h0020, 32'h0,       4'h0, 0, 0, 0, 0, 0, 2'b10, 32'h55AA33CC, 10);
        vecs[4] = mk(1, 16'h0100, 32'h01234567, 4'h1, 2, 2, 3, 0, 0, 2'b11, 32'h0, 2);
        vecs[5] = mk(0, 16'hFFFC, 32'h0,       4'h0, 0, 0, 0, 2, 1, 2'b11, 32'hCAFEF00D, 1);
        vecs[6] = mk(1, 16'h0ABC, 32'h89ABCDEF, 4'hC, 0, 3, 1, 0, 0, 2'b10, 32'h0, 0);
        vecs[7] = mk(0, 16'h1234, 32'h0,       4'h0, 0, 0, 0, 0, 0, 2'b00, 32'h0BADF00D, 0);

        rst = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
        rsp_ready = 0;
        cfg_aw_wait = 0; cfg_w_wait = 0; cfg_b_wait = 0; cfg_ar_wait = 0; cfg_r_wait = 0;
        cfg_resp = 0; cfg_rdata = 0;
        tx_aw = 0; tx_w = 0; tx_ar = 0; b_sent = 1; r_sent = 1;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_cmd_ready", cmd_ready, 0);
        chk("reset_busy", busy, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        rst = 0;
        @(negedge clk);
        chk("post_reset_cmd_ready", cmd_ready, 1);
        chk("post_reset_rsp_rdata", rsp_rdata, 0);
        chk("post_reset_rsp_resp", rsp_resp, 0);
        chk("post_reset_awaddr", awaddr, 0);
        chk("awprot", awprot, 0);
        chk("arprot", arprot, 0);

        // Table-driven transactions
        for (int i = 0; i < 8; i++) begin
            issue(vecs[i], acc);
            if (acc >= 0) complete(vecs[i], acc, i);
            if (i == 3) begin
                // Unsolicited B/R beats while idle must be ignored.
                bvalid = 1; rvalid = 1;
                #1;
                chk("spurious_bready", bready, 0);
                chk("spurious_rready", rready, 0);
                @(negedge clk);
                bvalid = 0; rvalid = 0;
                chk("spurious_rsp_valid", rsp_valid, 0);
                chk("spurious_busy", busy, 0);
            end
        end

        // Reset while waiting in WRESP, then a normal write
        v = mk(1, 16'h0200, 32'h11112222, 4'hF, 0, 0, 50, 0, 0, 2'b00, 32'h0, 0);
        issue(v, acc);
        n = 0;
        while (!bready && n < 20) begin @(negedge clk); n++; end
        chk("reached_wresp", bready, 1);
        rst = 1; slave_rst = 1;
        #1;
        chk("rst_awvalid", awvalid, 0);
        chk("rst_wvalid", wvalid, 0);
        chk("rst_bready", bready, 0);
        chk("rst_arvalid", arvalid, 0);
        chk("rst_rready", rready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cmd_ready", cmd_ready, 0);
        @(negedge clk);
        rst = 0;
        #1;
        chk("after_rst_busy", busy, 0);
        chk("after_rst_cmd_ready", cmd_ready, 1);
        chk("after_rst_awvalid", awvalid, 0);
        chk("after_rst_awaddr", awaddr, 0);
        chk("after_rst_wdata", wdata, 0);
        chk("after_rst_rsp_write", rsp_write, 0);
        dummy = sb.pop_back();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("after_rst_no_rsp", rsp_valid, 0);
        end
        slave_rst = 0;
        @(negedge clk);
        v = mk(1, 16'h0204, 32'h33334444, 4'h6, 1, 0, 0, 0, 0, 2'b00, 32'h0, 0);
        issue(v, acc);
        if (acc >= 0) complete(v, acc, 8);

`ifdef SASANQUA_AXI_MASTER_TIMEOUT_EN
        // Slave withholds ARREADY past the watchdog limit.
        v = mk(0, 16'h0040, 32'h0, 4'h0, 0, 0, 0, 30, 0, 2'b00, 32'h600DCAFE, 0);
        issue(v, acc);
        for (int j = 1; j <= 17; j++) begin
            if (j == 16) chk("timeout_before_limit", timeout, 0);
            if (j == 17) begin
                chk("timeout_at_limit", timeout, 1);
                chk("timeout_arvalid_held", arvalid, 1);
            end
            if (j < 17) @(negedge clk);
        end
        if (acc >= 0) complete(v, acc, 9);
        chk("timeout_sticky", timeout, 1);
        v = vecs[7];
        issue(v, acc);
        if (acc >= 0) complete(v, acc, 10);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
